// File: rtl/ft832_bus_responder.sv
// ft832_bus_responder: CPU bus slave exposing a 2^AWID byte RAM window at BASE_ADDR.
// Latency: WAIT+1 cycles from select to rdy=1 (1 cycle when FT832_BUSRESP_WAIT_EN is undefined).
// Backpressure: rdy=0 stalls the CPU while an access is pending; out-of-window cycles see rdy=1.
// Build option: define FT832_BUSRESP_WAIT_EN to honour WAIT (WAIT state and countdown present).
module ft832_bus_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter int          AWID      = 10,
  parameter int          WAIT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vda,
  input  logic        rw,
  input  logic [31:0] ad,
  input  logic [7:0]  db_i,
  output logic [7:0]  db_o,
  output logic        db_oe,
  output logic        rdy
);

  // The countdown register is 4 bits wide, so WAIT beyond 15 cannot be represented.
  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("ft832_bus_responder: WAIT must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AWID-1:0] r_addr;
  logic            r_rw;
  logic [7:0]      r_wdat;
  logic [7:0]      r_dbo;
  logic [7:0]      r_mem [0:(1<<AWID)-1];

  logic            w_sel;
  logic            w_accept;
  logic            w_abort;
  logic            w_rdy;
  logic [AWID-1:0] w_rd_addr;
  logic            w_rd_rw;

  assign w_sel    = vda && (ad[31:AWID] == BASE_ADDR[31:AWID]);
  assign w_accept = (r_state == S_IDLE) && w_sel;

`ifdef FT832_BUSRESP_WAIT_EN
  logic [3:0] r_cnt;

  // The CPU must hold the same request through WAIT; any change cancels the access.
  assign w_abort = (r_state == S_WAIT) &&
                   (!w_sel || (ad[AWID-1:0] != r_addr) || (rw != r_rw));

  // Wait countdown: loaded when a request is accepted, decremented while waiting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= 4'(WAIT);
    end else if ((r_state == S_WAIT) && !w_abort && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and ready: rdy drops on the accept cycle and stays low through WAIT.
  always_comb begin
    w_next = r_state;
    w_rdy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_rdy = 1'b0;
`ifdef FT832_BUSRESP_WAIT_EN
          w_next = (WAIT > 0) ? S_WAIT : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef FT832_BUSRESP_WAIT_EN
      S_WAIT: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else begin
          w_rdy = 1'b0;
          if (r_cnt == 4'd1) begin
            w_next = S_DONE;
          end
        end
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, captured on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr <= '0;
      r_rw   <= 1'b0;
      r_wdat <= 8'h00;
    end else if (w_accept) begin
      r_addr <= ad[AWID-1:0];
      r_rw   <= rw;
      r_wdat <= db_i;
    end
  end

  // On the IDLE->DONE shortcut the latch is loading on the same edge, so use the live bus.
  assign w_rd_addr = (r_state == S_IDLE) ? ad[AWID-1:0] : r_addr;
  assign w_rd_rw   = (r_state == S_IDLE) ? rw : r_rw;

  // Read data register: loaded only when a read enters DONE, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbo <= 8'h00;
    end else if ((w_next == S_DONE) && (r_state != S_DONE) && w_rd_rw) begin
      r_dbo <= r_mem[w_rd_addr];
    end
  end

  // RAM write commits on the edge leaving DONE; a reset on that edge cancels it. No array reset.
  always_ff @(posedge clk) begin
    if (rst && (r_state == S_DONE) && !r_rw) begin
      r_mem[r_addr] <= r_wdat;
    end
  end

  assign db_o  = r_dbo;
  assign db_oe = (r_state == S_DONE) && r_rw;
  assign rdy   = w_rdy;

endmodule

// File: tb/tb_ft832_bus_responder.sv
// tb_ft832_bus_responder: scoreboard bench for ft832_bus_responder (WAIT=2 instance).
// Expected read data is queued at issue and popped when the read completes.
// Expected latency follows the build: WAIT+1 with FT832_BUSRESP_WAIT_EN, else 1.
`timescale 1ns/1ps
module tb_ft832_bus_responder;

`ifdef FT832_BUSRESP_WAIT_EN
  localparam int EXP_LOW = 3;
`else
  localparam int EXP_LOW = 1;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        vda  = 1'b0;
  logic        rw   = 1'b1;
  logic [31:0] ad   = 32'h0;
  logic [7:0]  db_i = 8'h00;
  logic [7:0]  db_o;
  logic        db_oe;
  logic        rdy;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [0:1023];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ft832_bus_responder #(
    .BASE_ADDR (32'h0000_F000),
    .AWID      (10),
    .WAIT      (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .vda   (vda),
    .rw    (rw),
    .ad    (ad),
    .db_i  (db_i),
    .db_o  (db_o),
    .db_oe (db_oe),
    .rdy   (rdy)
  );

  // Present a request and hold it until rdy is seen high; returns at the negedge of that cycle.
  task automatic bus_cycle(input logic [31:0] a, input logic r, input logic [7:0] d,
                           output int low, output logic oe, output logic [7:0] q,
                           output logic to);
    logic found;
    @(posedge clk); #1;
    vda = 1'b1; ad = a; rw = r; db_i = d;
    low = 0; oe = 1'b0; q = 8'h00; found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        found = 1'b1;
        oe = db_oe;
        q  = db_o;
        break;
      end
      low++;
    end
    to = !found;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    vda = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; vda = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
    checks++;
    if (db_oe !== 1'b0) begin errors++; $display("FAIL reset_db_oe: got %b expected 0", db_oe); end
    checks++;
    if (db_o !== 8'h00) begin errors++; $display("FAIL reset_db_o: got %h expected 00", db_o); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    bus_cycle(32'h0000_F005, 1'b0, 8'hA5, low, oe, q, to);
    model_mem[10'h005] = 8'hA5;
    checks++;
    if (to || low != EXP_LOW) begin errors++; $display("FAIL wr_latency: got %0d (timeout=%b) expected %0d", low, to, EXP_LOW); end
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL wr_db_oe: got %b expected 0", oe); end
    bus_idle();
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy_after: got %b expected 1", rdy); end
    exp_q.push_back(model_mem[10'h005]);
    bus_cycle(32'h0000_F005, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || low != EXP_LOW) begin errors++; $display("FAIL rd_latency: got %0d (timeout=%b) expected %0d", low, to, EXP_LOW); end
    checks++;
    if (oe !== 1'b1) begin errors++; $display("FAIL rd_db_oe: got %b expected 1", oe); end
    checks++;
    if (q !== e) begin errors++; $display("FAIL rd_data: got %h expected %h", q, e); end
    bus_idle();
    @(negedge clk);
    checks++;
    if (db_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_after: got %b expected 0", db_oe); end
    checks++;
    if (db_o !== e) begin errors++; $display("FAIL rd_hold: got %h expected %h", db_o, e); end
  endtask

  task automatic test_outside();
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    @(posedge clk); #1;
    vda = 1'b1; rw = 1'b1; ad = 32'h0001_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1 || db_oe !== 1'b0) begin
        errors++; $display("FAIL out_read: rdy=%b db_oe=%b expected rdy=1 db_oe=0", rdy, db_oe);
      end
    end
    @(posedge clk); #1;
    rw = 1'b0; db_i = 8'h00; ad = 32'h0000_F400;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b1 || db_oe !== 1'b0) begin
        errors++; $display("FAIL out_write: rdy=%b db_oe=%b expected rdy=1 db_oe=0", rdy, db_oe);
      end
    end
    bus_idle();
    exp_q.push_back(model_mem[10'h005]);
    bus_cycle(32'h0000_F005, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || low != EXP_LOW) begin errors++; $display("FAIL out_latency: got %0d expected %0d", low, EXP_LOW); end
    checks++;
    if (q !== e) begin errors++; $display("FAIL out_ram: got %h expected %h", q, e); end
    bus_idle();
  endtask

  task automatic test_wrap();
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    bus_cycle(32'h0000_F000, 1'b0, 8'h5A, low, oe, q, to);
    model_mem[10'h000] = 8'h5A;
    bus_cycle(32'h0000_F3FF, 1'b0, 8'h3C, low, oe, q, to);
    model_mem[10'h3FF] = 8'h3C;
    checks++;
    if (to || low != EXP_LOW) begin errors++; $display("FAIL wrap_wr_latency: got %0d expected %0d", low, EXP_LOW); end
    exp_q.push_back(model_mem[10'h3FF]);
    bus_cycle(32'h0000_F3FF, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || q !== e) begin errors++; $display("FAIL wrap_last: got %h expected %h", q, e); end
    exp_q.push_back(model_mem[10'h000]);
    bus_cycle(32'h0000_F000, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || q !== e) begin errors++; $display("FAIL wrap_first: got %h expected %h", q, e); end
    bus_idle();
  endtask

  task automatic test_abort();
`ifdef FT832_BUSRESP_WAIT_EN
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    bus_cycle(32'h0000_F010, 1'b0, 8'h44, low, oe, q, to);
    model_mem[10'h010] = 8'h44;
    bus_idle();
    // Abort by dropping vda in WAIT.
    @(posedge clk); #1;
    vda = 1'b1; rw = 1'b0; ad = 32'h0000_F010; db_i = 8'h77;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL abort_accept_rdy: got %b expected 0", rdy); end
    @(posedge clk); #1;
    vda = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL abort_vda_rdy: got %b expected 1", rdy); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || db_oe !== 1'b0) begin
      errors++; $display("FAIL abort_vda_idle: rdy=%b db_oe=%b expected rdy=1 db_oe=0", rdy, db_oe);
    end
    // Abort by flipping rw in WAIT.
    @(posedge clk); #1;
    vda = 1'b1; rw = 1'b0; ad = 32'h0000_F010; db_i = 8'h88;
    @(posedge clk); #1;
    rw = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL abort_rw_rdy: got %b expected 1", rdy); end
    bus_idle();
    exp_q.push_back(model_mem[10'h010]);
    bus_cycle(32'h0000_F010, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || q !== e) begin errors++; $display("FAIL abort_ram: got %h expected %h", q, e); end
    bus_idle();
`endif
  endtask

  task automatic test_reset_mid();
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    bus_cycle(32'h0000_F020, 1'b0, 8'h55, low, oe, q, to);
    model_mem[10'h020] = 8'h55;
    bus_cycle(32'h0000_F020, 1'b0, 8'h11, low, oe, q, to);
    checks++;
    if (to) begin errors++; $display("FAIL rstmid_done: got timeout expected rdy in DONE"); end
    // Now in DONE of the 8'h11 write: reset on the closing edge.
    rst = 1'b0; vda = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL rstmid_rdy: got %b expected 1", rdy); end
    checks++;
    if (db_oe !== 1'b0) begin errors++; $display("FAIL rstmid_db_oe: got %b expected 0", db_oe); end
    checks++;
    if (db_o !== 8'h00) begin errors++; $display("FAIL rstmid_db_o: got %h expected 00", db_o); end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(model_mem[10'h020]);
    bus_cycle(32'h0000_F020, 1'b1, 8'h00, low, oe, q, to);
    e = exp_q.pop_front();
    checks++;
    if (to || q !== e) begin errors++; $display("FAIL rstmid_ram: got %h expected %h", q, e); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    int low; logic oe; logic [7:0] q; logic to; logic [7:0] e;
    logic [9:0] a; logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 10'h100 + 10'(i * 37);
      d = 8'($urandom_range(0, 255));
      bus_cycle({22'h00003C, a}, 1'b0, d, low, oe, q, to);
      model_mem[a] = d;
      checks++;
      if (to || low != EXP_LOW) begin errors++; $display("FAIL b2b_wr_latency[%0d]: got %0d expected %0d", i, low, EXP_LOW); end
    end
    for (int i = 0; i < 8; i++) begin
      a = 10'h100 + 10'(i * 37);
      exp_q.push_back(model_mem[a]);
      bus_cycle({22'h00003C, a}, 1'b1, 8'h00, low, oe, q, to);
      e = exp_q.pop_front();
      checks++;
      if (to || low != EXP_LOW || oe !== 1'b1 || q !== e) begin
        errors++;
        $display("FAIL b2b_rd[%0d]: data=%h oe=%b lat=%0d expected data=%h oe=1 lat=%0d", i, q, oe, low, e, EXP_LOW);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_outside();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
